// File: rtl/game2048_pkg.sv
// -----------------------------------------------------------------------------
// game2048_pkg
// Shared definitions for the PS/2 keyboard front end of the game:
//   - PS/2 set-2 scan-code constants for the prefix bytes and mapped keys
//   - receiver FSM state encoding
//   - one-hot key mask layout used by the move decoder
//   - helpers: odd-parity check and scan-code to key-mask lookup
// -----------------------------------------------------------------------------
package game2048_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;  // extended-key prefix
    localparam logic [7:0] SC_BRK   = 8'hF0;  // break (key release) prefix

    // Mapped keys (arrows are extended codes, 'S' is not)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_START = 8'h1B;

    // Receiver FSM states
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // One-hot key mask layout: bit0 up, bit1 down, bit2 left, bit3 right, bit4 start
    localparam int unsigned KEY_N     = 5;
    localparam logic [4:0]  KEY_UP    = 5'b00001;
    localparam logic [4:0]  KEY_DOWN  = 5'b00010;
    localparam logic [4:0]  KEY_LEFT  = 5'b00100;
    localparam logic [4:0]  KEY_RIGHT = 5'b01000;
    localparam logic [4:0]  KEY_START = 5'b10000;
    localparam logic [4:0]  KEY_NONE  = 5'b00000;

    // True when data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Map a scan code (with its extended flag) to a one-hot key mask.
    // Unmapped codes return KEY_NONE.
    function automatic logic [4:0] key_onehot(input logic ext, input logic [7:0] code);
        logic [4:0] mask;
        mask = KEY_NONE;
        if (ext) begin
            case (code)
                SC_UP:    mask = KEY_UP;
                SC_DOWN:  mask = KEY_DOWN;
                SC_LEFT:  mask = KEY_LEFT;
                SC_RIGHT: mask = KEY_RIGHT;
                default:  mask = KEY_NONE;
            endcase
        end else begin
            if (code == SC_START) begin
                mask = KEY_START;
            end else begin
                mask = KEY_NONE;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver. Synchronises the keyboard clock and data
// into the system clock domain, detects keyboard-clock falling edges, and runs
// an IDLE/DATA/PARITY/STOP FSM with an inactivity timeout.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   ps2_clk_i    keyboard clock (asynchronous)
//   ps2_dat_i    keyboard data (asynchronous)
//   byte_o       received byte (valid while byte_valid_o is high)
//   byte_valid_o one-cycle strobe: good frame completed on this stop edge
//   err_o        one-cycle strobe: frame discarded (parity, stop or timeout)
//
// The strobes are decoded from registered state and the synchronised inputs
// in the stop-edge cycle itself, so the consumer can register its response
// and still answer in the cycle right after the edge is detected.
// -----------------------------------------------------------------------------
module ps2_rx
    import game2048_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);

    // Counter only needs to reach TIMEOUT_CYCLES-1
    localparam int unsigned    TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             clk_meta_q;
    logic             clk_sync_q;
    logic             clk_prev_q;
    logic             dat_meta_q;
    logic             dat_sync_q;

    rx_state_e        state_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_cnt_q;
    logic             par_q;
    logic [TMO_W-1:0] tmo_q;

    logic             fall_s;
    logic             tmo_expire_s;
    logic             stop_edge_s;
    logic             frame_ok_s;

    // Two-flop synchronisers plus a delayed clock copy for edge detection; idle bus is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_i;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_i;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall_s       = clk_prev_q & ~clk_sync_q;
    // Counter holds the number of edge-free cycles already spent mid-frame;
    // this cycle is the TIMEOUT_CYCLES-th one when it reads TMO_LAST.
    assign tmo_expire_s = (state_q != RX_IDLE) & ~fall_s & (tmo_q == TMO_LAST);
    assign stop_edge_s  = fall_s & (state_q == RX_STOP);
    assign frame_ok_s   = dat_sync_q & odd_parity_ok(shift_q, par_q);

    assign byte_o       = shift_q;
    assign byte_valid_o = stop_edge_s & frame_ok_s;
    assign err_o        = (stop_edge_s & ~frame_ok_s) | tmo_expire_s;

    // Receiver FSM with bit counter, shift register and inactivity timer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RX_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            par_q     <= 1'b0;
            tmo_q     <= {TMO_W{1'b0}};
        end else begin
            if ((state_q == RX_IDLE) || fall_s || tmo_expire_s) begin
                tmo_q <= {TMO_W{1'b0}};
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            case (state_q)
                RX_IDLE: begin
                    // Only a low data bit is a start bit; a high one is noise
                    if (fall_s && !dat_sync_q) begin
                        state_q   <= RX_DATA;
                        bit_cnt_q <= 3'd0;
                        shift_q   <= 8'h00;
                    end
                end
                RX_DATA: begin
                    if (tmo_expire_s) begin
                        state_q <= RX_IDLE;
                        shift_q <= 8'h00;
                    end else if (fall_s) begin
                        shift_q   <= {dat_sync_q, shift_q[7:1]};  // LSB arrives first
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= RX_PARITY;
                        end
                    end
                end
                RX_PARITY: begin
                    if (tmo_expire_s) begin
                        state_q <= RX_IDLE;
                        shift_q <= 8'h00;
                    end else if (fall_s) begin
                        par_q   <= dat_sync_q;
                        state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (tmo_expire_s) begin
                        state_q <= RX_IDLE;
                        shift_q <= 8'h00;
                    end else if (fall_s) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// -----------------------------------------------------------------------------
// ps2_move_decoder
// Turns PS/2 keyboard frames into one-cycle game control pulses. Frame
// reception lives in ps2_rx; this level tracks the E0 (extended) and F0
// (break) prefixes and a held-key mask that suppresses typematic repeat.
//
// Ports
//   clock      system clock (50 MHz)
//   resetn     asynchronous active-low reset
//   PS2_CLK    keyboard clock (asynchronous)
//   PS2_DAT    keyboard data (asynchronous)
//   up/down/left/right  one-cycle move pulses (E0 75/72/6B/74 make codes)
//   start      one-cycle pulse on the 'S' make code (1B)
//   frame_err  one-cycle pulse for each discarded frame
// All outputs are registered and high in the cycle after the stop-bit edge.
// -----------------------------------------------------------------------------
module ps2_move_decoder
    import game2048_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clock,
    input  logic resetn,
    input  logic PS2_CLK,
    input  logic PS2_DAT,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic start,
    output logic frame_err
);

    logic [7:0]       rx_byte_s;
    logic             rx_valid_s;
    logic             rx_err_s;
    logic [KEY_N-1:0] key_mask_s;

    logic             ext_q;
    logic             brk_q;
    logic [KEY_N-1:0] held_q;
    logic [KEY_N-1:0] pulse_q;
    logic             frame_err_q;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ps2_rx (
        .clk_i        (clock),
        .rst_ni       (resetn),
        .ps2_clk_i    (PS2_CLK),
        .ps2_dat_i    (PS2_DAT),
        .byte_o       (rx_byte_s),
        .byte_valid_o (rx_valid_s),
        .err_o        (rx_err_s)
    );

    assign key_mask_s = key_onehot(ext_q, rx_byte_s);

    // Prefix flags, held mask and registered output pulses
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= {KEY_N{1'b0}};
            pulse_q     <= {KEY_N{1'b0}};
            frame_err_q <= 1'b0;
        end else begin
            pulse_q     <= {KEY_N{1'b0}};
            frame_err_q <= 1'b0;
            if (rx_err_s) begin
                // Discarded frame breaks any prefix sequence; held keys stay held
                ext_q       <= 1'b0;
                brk_q       <= 1'b0;
                frame_err_q <= 1'b1;
            end else if (rx_valid_s) begin
                if (rx_byte_s == SC_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte_s == SC_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    // Any final byte consumes the prefixes, mapped or not
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (brk_q) begin
                        held_q <= held_q & ~key_mask_s;
                    end else begin
                        // key_mask_s is one-hot or zero, so pulses stay exclusive
                        held_q  <= held_q | key_mask_s;
                        pulse_q <= key_mask_s & ~held_q;
                    end
                end
            end else begin
                ext_q <= ext_q;
                brk_q <= brk_q;
            end
        end
    end

    assign up        = pulse_q[0];
    assign down      = pulse_q[1];
    assign left      = pulse_q[2];
    assign right     = pulse_q[3];
    assign start     = pulse_q[4];
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_move_decoder
// Directed table of PS/2 frames with expected pulse counts, plus hand-written
// sequences for idle noise, timeout and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_ps2_move_decoder;

    localparam int unsigned TMO = 100;

    logic clock   = 1'b0;
    logic resetn  = 1'b0;
    logic PS2_CLK = 1'b1;
    logic PS2_DAT = 1'b1;
    logic up, down, left, right, start, frame_err;

    ps2_move_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .start     (start),
        .frame_err (frame_err)
    );

    always #10 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cnt[6];     // high cycles seen: up, down, left, right, start, frame_err
    int base[6];
    int n_excl = 0;
    int pulse_cyc = 0;
    int last_fall_cyc = 0;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        logic [5:0] exp;     // {up, down, left, right, start, frame_err}
    } vec_t;

    vec_t vecs[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor, sampled on the inactive edge
    initial for (int i = 0; i < 6; i++) cnt[i] = 0;
    always @(negedge clock) begin
        if (up)        cnt[0]++;
        if (down)      cnt[1]++;
        if (left)      cnt[2]++;
        if (right)     cnt[3]++;
        if (start)     cnt[4]++;
        if (frame_err) cnt[5]++;
        if ($countones({up, down, left, right, start}) > 1) n_excl++;
        if (up | down | left | right | start) pulse_cyc = cyc;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic ps2_bit(input logic b);
        @(negedge clock);
        PS2_DAT = b;
        repeat (3) @(negedge clock);
        PS2_CLK = 1'b0;
        last_fall_cyc = cyc;
        repeat (5) @(negedge clock);
        PS2_CLK = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^code) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par);
        ps2_bit(~bad_stop);
        PS2_DAT = 1'b1;
    endtask

    task automatic snap();
        for (int i = 0; i < 6; i++) base[i] = cnt[i];
    endtask

    task automatic check_counts(input string name, input logic [5:0] exp);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if ((cnt[i] - base[i]) != int'(exp[5-i])) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got u/d/l/r/s/e=%0d/%0d/%0d/%0d/%0d/%0d, expected %b",
                     name, cnt[0]-base[0], cnt[1]-base[1], cnt[2]-base[2],
                     cnt[3]-base[3], cnt[4]-base[4], cnt[5]-base[5], exp);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        tests++;
        if ({up, down, left, right, start, frame_err} != 6'b000000) begin
            fails++;
            $display("FAIL %s: outputs=%b, expected 000000", name,
                     {up, down, left, right, start, frame_err});
        end
    endtask

    initial begin
        // {code, bad_par, bad_stop, expected {u,d,l,r,s,e}}
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h75, 1'b0, 1'b0, 6'b100000});  // up
        vecs.push_back('{8'h1B, 1'b0, 1'b0, 6'b000010});  // start
        vecs.push_back('{8'h1B, 1'b0, 1'b0, 6'b000000});  // typematic
        vecs.push_back('{8'h1B, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'hF0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h1B, 1'b0, 1'b0, 6'b000000});  // release S
        vecs.push_back('{8'h1B, 1'b0, 1'b0, 6'b000010});  // start again
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h6B, 1'b0, 1'b0, 6'b001000});  // left
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'hF0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h6B, 1'b0, 1'b0, 6'b000000});  // release left
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h74, 1'b0, 1'b0, 6'b000100});  // right
        vecs.push_back('{8'h1C, 1'b1, 1'b0, 6'b000001});  // parity error
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h72, 1'b0, 1'b0, 6'b010000});  // down
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h1F, 1'b0, 1'b0, 6'b000000});  // unmapped extended
        vecs.push_back('{8'h75, 1'b0, 1'b0, 6'b000000});  // keypad 8, not extended
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'hF0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h75, 1'b0, 1'b0, 6'b000000});  // release up
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h1C, 1'b1, 1'b0, 6'b000001});  // error clears ext
        vecs.push_back('{8'h75, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h75, 1'b0, 1'b0, 6'b100000});  // up after release
        vecs.push_back('{8'h1B, 1'b0, 1'b1, 6'b000001});  // stop-bit error
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'hF0, 1'b0, 1'b0, 6'b000000});
        vecs.push_back('{8'h74, 1'b0, 1'b0, 6'b000000});  // release right

        // Reset state
        repeat (3) @(negedge clock);
        check_zero_outputs("reset_outputs");
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        check_zero_outputs("post_reset_outputs");

        // Table-driven frames
        foreach (vecs[k]) begin
            snap();
            send_frame(vecs[k].code, vecs[k].bad_par, vecs[k].bad_stop);
            repeat (2) @(negedge clock);
            check_counts($sformatf("vec%0d_%h", k, vecs[k].code), vecs[k].exp);
            if (vecs[k].exp[5:1] != 5'b00000) begin
                tests++;
                if (pulse_cyc - last_fall_cyc != 3) begin
                    fails++;
                    $display("FAIL latency_vec%0d: got %0d cycles after stop edge, expected 3",
                             k, pulse_cyc - last_fall_cyc);
                end
            end
        end

        // Idle edge with data high is ignored; following frames stay aligned
        snap();
        ps2_bit(1'b1);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h72, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h72, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check_counts("idle_noise_then_down", 6'b010000);

        // Partial frame then silence: timeout
        snap();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        repeat (50) @(negedge clock);
        check_counts("timeout_not_early", 6'b000000);
        repeat (100) @(negedge clock);
        check_counts("timeout_err", 6'b000001);
        snap();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check_counts("after_timeout_right", 6'b000100);

        // Reset during 5th data bit of E0
        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        @(negedge clock);
        PS2_DAT = 1'b0;
        repeat (3) @(negedge clock);
        PS2_CLK = 1'b0;
        repeat (2) @(negedge clock);
        #3 resetn = 1'b0;
        #2 check_zero_outputs("async_reset_outputs");
        repeat (2) @(negedge clock);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check_counts("reset_midframe_then_up", 6'b100000);

        tests++;
        if (n_excl != 0) begin
            fails++;
            $display("FAIL exclusive_pulses: got %0d overlapping cycles, expected 0", n_excl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
